// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_SELW  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Opcode names for the external ALU; the arbiter only forwards them.
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_XNOR = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_PASA = 4'b1010;
  localparam logic [3:0] OP_PASB = 4'b1011;
  localparam logic [3:0] OP_NOTA = 4'b1100;
  localparam logic [3:0] OP_INC  = 4'b1101;
  localparam logic [3:0] OP_DEC  = 4'b1110;
  localparam logic [3:0] OP_SLT  = 4'b1111;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on contention the
// requester that was not granted last wins. Output is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // Grant decode from request vector and previous winner.
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU, one
// operation in flight at a time (IDLE -> EXEC -> RESP).
// Optional macro ALU_ARB_STATS_EN enables saturating per-requester
// completed-grant counters on cnt0/cnt1; otherwise they are tied to 0.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SELW  = DEF_SELW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [SELW-1:0]  req0_sel,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [SELW-1:0]  req1_sel,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_y,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_y,
  output logic [SELW-1:0]  alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  state_t           state, state_nxt;
  logic             last_grant;
  logic             owner;
  logic [SELW-1:0]  op_sel;
  logic [WIDTH-1:0] op_a, op_b, result;
  logic [1:0]       gnt;
  logic             xfer;
  logic             rsp_done;

  rr_arb2 u_rr (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Next-state and output decode; ready is masked during reset so no
  // requester believes an operation was accepted that reset discards.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_y     = '0;
    rsp1_y     = '0;
    alu_sel    = '0;
    alu_a      = '0;
    alu_b      = '0;
    xfer       = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          req0_ready = gnt[0];
          req1_ready = gnt[1];
        end
        xfer = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        if (xfer) state_nxt = EXEC;
      end
      EXEC: begin
        alu_sel   = op_sel;
        alu_a     = op_a;
        alu_b     = op_b;
        state_nxt = RESP;
      end
      RESP: begin
        if (owner) begin
          rsp1_valid = 1'b1;
          rsp1_y     = result;
          rsp_done   = rsp1_ready;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_y     = result;
          rsp_done   = rsp0_ready;
        end
        if (rsp_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, operand latch on accept, result capture in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_sel     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      result     <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        op_sel     <= gnt[1] ? req1_sel : req0_sel;
        op_a       <= gnt[1] ? req1_a   : req0_a;
        op_b       <= gnt[1] ? req1_b   : req0_b;
        owner      <= gnt[1];
        last_grant <= gnt[1];
      end
      if (state == EXEC) result <= alu_y;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  // Saturating completed-grant counters, stepped on owner handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (rsp_done) begin
      if (!owner && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (owner  && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with an attached ALU model.
module tb_alu_arbiter;

  localparam int W = 4;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [S-1:0] req0_sel = '0, req1_sel = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp0_y, rsp1_y;
  logic [S-1:0] alu_sel;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [15:0]  cnt0, cnt1;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .SELW(S)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  function automatic logic [W-1:0] alu_fn(input logic [S-1:0] s,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a & b);
      4'd6:    return ~(a | b);
      4'd7:    return ~(a ^ b);
      4'd8:    return a << 1;
      4'd9:    return a >> 1;
      4'd10:   return a;
      4'd11:   return b;
      4'd12:   return ~a;
      4'd13:   return a + 4'd1;
      4'd14:   return a - 4'd1;
      default: return (a < b) ? 4'd1 : 4'd0;
    endcase
  endfunction

  assign alu_y = alu_fn(alu_sel, alu_a, alu_b);

  typedef struct {
    int           owner;
    logic [S-1:0] sel;
    logic [W-1:0] a, b, y;
    int           acc;
  } exp_t;

  typedef struct {
    logic [S-1:0] sel;
    logic [W-1:0] a, b;
  } op_t;

  exp_t sb[$];
  op_t  q0[$], q1[$];
  int   grant_log[$];
  int   tests = 0, fails = 0;
  int   cyc = 0;
  int   model_last = 1;
  int   cnt_m[2] = '{0, 0};
  int   hold1 = 0;
  int   pv0 = 0, pv1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response consumer: random ready, optional forced stall on requester 1.
  initial begin
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp1_valid && hold1 > 0) begin
        rsp1_ready = 1'b0;
        hold1--;
      end else begin
        rsp1_ready = 1'($urandom_range(0, 1));
      end
      rsp0_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: checks ALU drive, response owner/value/latency against scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pv0 = 0;
        pv1 = 0;
      end else begin
        if (sb.size() > 0 && cyc == sb[0].acc + 1) begin
          check("alu_sel", alu_sel, sb[0].sel);
          check("alu_a", alu_a, sb[0].a);
          check("alu_b", alu_b, sb[0].b);
        end else begin
          check("alu_idle", {alu_sel, alu_a, alu_b}, 0);
        end
        if (rsp0_valid || rsp1_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", {rsp1_valid, rsp0_valid}, 0);
          end else begin
            exp_t e;
            logic rdy;
            e = sb[0];
            check("rsp_owner", {rsp1_valid, rsp0_valid}, (e.owner == 1) ? 2 : 1);
            check("rsp_y", (e.owner == 1) ? rsp1_y : rsp0_y, e.y);
            check("rsp_other_y", (e.owner == 1) ? rsp0_y : rsp1_y, 0);
            if ((e.owner == 1 ? pv1 : pv0) == 0) check("latency", cyc, e.acc + 2);
            if (e.owner == 1) pv1 = 1; else pv0 = 1;
            rdy = (e.owner == 1) ? rsp1_ready : rsp0_ready;
            if (rdy) begin
              if (e.owner == 1) pv1 = 0; else pv0 = 0;
              if (cnt_m[e.owner] < 65535) cnt_m[e.owner]++;
              void'(sb.pop_front());
            end
          end
        end else begin
          check("rsp_idle_y", {rsp1_y, rsp0_y}, 0);
          if (sb.size() > 0 && cyc >= sb[0].acc + 2) check("rsp_missing", 0, 1);
        end
      end
    end
  end

  function automatic op_t rand_op();
    op_t o;
    o.sel = S'($urandom);
    o.a   = W'($urandom);
    o.b   = W'($urandom);
    return o;
  endfunction

  task automatic accept(input int n);
    exp_t e;
    op_t  o;
    o = (n == 1) ? q1[0] : q0[0];
    e.owner = n;
    e.sel   = o.sel;
    e.a     = o.a;
    e.b     = o.b;
    e.y     = alu_fn(o.sel, o.a, o.b);
    e.acc   = cyc;
    sb.push_back(e);
    grant_log.push_back(n);
    model_last = n;
    if (n == 1) void'(q1.pop_front()); else void'(q0.pop_front());
  endtask

  // Drives queued ops, checks the ready pattern against the grant rules.
  task automatic run_ops();
    int   budget;
    logic [1:0] exp_r;
    op_t  o;
    budget = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && budget < 3000) begin
      @(negedge clk);
      budget++;
      o = (q0.size() > 0) ? q0[0] : rand_op();
      req0_valid = (q0.size() > 0);
      req0_sel = o.sel; req0_a = o.a; req0_b = o.b;
      o = (q1.size() > 0) ? q1[0] : rand_op();
      req1_valid = (q1.size() > 0);
      req1_sel = o.sel; req1_a = o.a; req1_b = o.b;
      #1;
      exp_r = 2'b00;
      if (sb.size() == 0) begin
        if (req0_valid && req1_valid) exp_r = (model_last == 1) ? 2'b01 : 2'b10;
        else exp_r = {req1_valid, req0_valid};
      end
      check("req_ready", {req1_ready, req0_ready}, exp_r);
      if (req0_valid && req0_ready) accept(0);
      else if (req1_valid && req1_ready) accept(1);
    end
    if (budget >= 3000) check("timeout", 0, 1);
  endtask

  task automatic check_cnt();
`ifdef ALU_ARB_STATS_EN
    check("cnt0", cnt0, cnt_m[0]);
    check("cnt1", cnt1, cnt_m[1]);
`else
    check("cnt0_off", cnt0, 0);
    check("cnt1_off", cnt1, 0);
`endif
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    sb.delete();
    model_last = 1;
    cnt_m = '{0, 0};
    check("rst_out", {req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp1_y, rsp0_y,
                      alu_sel, alu_a, alu_b, cnt0, cnt1}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_out", {req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp1_y, rsp0_y,
                           alu_sel, alu_a, alu_b, cnt0, cnt1}, 0);
  endtask

  initial begin
    op_t o;
    do_reset(3);

    // Opcode sweep on requester 0.
    for (int i = 0; i < 16; i++) begin
      o.sel = 4'(i); o.a = 4'b1111; o.b = 4'b1100;
      q0.push_back(o);
    end
    run_ops();
    check_cnt();

    // Contention from reset: alternating grants starting with requester 0.
    do_reset(1);
    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    run_ops();
    check("grant_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      check("grant0", grant_log[0], 0);
      check("grant1", grant_log[1], 1);
      check("grant2", grant_log[2], 0);
      check("grant3", grant_log[3], 1);
    end
`ifdef ALU_ARB_STATS_EN
    check("cnt0_two", cnt0, 2);
    check("cnt1_two", cnt1, 2);
`endif
    check_cnt();

    // Requester 1 response stalled for five cycles.
    hold1 = 5;
    q1.push_back(rand_op());
    q0.push_back(rand_op());
    run_ops();
    check("hold_applied", hold1, 0);

    // Reset while an operation is executing; it must vanish.
    @(negedge clk);
    o = rand_op();
    req0_valid = 1'b1; req0_sel = o.sel; req0_a = o.a; req0_b = o.b;
    req1_valid = 1'b1;
    #1;
    check("pre_rst_grant", {req1_ready, req0_ready}, (model_last == 1) ? 2'b01 : 2'b10);
    do_reset(1);
    repeat (4) @(negedge clk);
    grant_log.delete();
    q0.push_back(rand_op());
    q1.push_back(rand_op());
    run_ops();
    check("rst_first_grant", (grant_log.size() > 0) ? grant_log[0] : 9, 0);
    check_cnt();

    // Random batches on both requesters.
    for (int k = 0; k < 8; k++) begin
      int n0, n1;
      n0 = $urandom_range(0, 4);
      n1 = $urandom_range(0, 4);
      for (int i = 0; i < n0; i++) q0.push_back(rand_op());
      for (int i = 0; i < n1; i++) q1.push_back(rand_op());
      run_ops();
    end
    check_cnt();

`ifdef ALU_ARB_STATS_EN
    // Counter saturation from a preloaded near-full value.
    @(negedge clk);
    force dut.cnt0_q = 16'hFFFE;
    #1;
    release dut.cnt0_q;
    cnt_m[0] = 65534;
    q0.push_back(rand_op());
    q0.push_back(rand_op());
    q0.push_back(rand_op());
    run_ops();
    check("cnt0_sat", cnt0, 16'hFFFF);
    check_cnt();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
